fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the width of all addresses and of the PC.
REQ-002 Parameter RESET_PC, default 0, SHALL be the PC value loaded on reset.
REQ-003 clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  SHALL be the reset: synchronous, active-high.
REQ-005 imem_req_valid  out  1  SHALL indicate a fetch request is presented.
REQ-006 imem_req_ready  in  1  SHALL indicate imem accepts the request this cycle.
REQ-007 imem_req_addr  out  XLEN  SHALL be the fetch address, equal to the current PC.
REQ-008 imem_rsp_valid  in  1  SHALL indicate imem_rsp_data is valid this cycle.
REQ-009 imem_rsp_data  in  32  SHALL be the fetched instruction word.
REQ-010 instr_valid  out  1  SHALL indicate instr_data/instr_pc are presented to decode.
REQ-011 instr_ready  in  1  SHALL indicate decode accepts the instruction.
REQ-012 instr_data  out  32  SHALL be the held instruction word.
REQ-013 instr_pc  out  XLEN  SHALL be the address instr_data was fetched from.
REQ-014 redirect_valid  in  1  SHALL request a PC redirect (taken branch/jump) this cycle.
REQ-015 redirect_base  in  XLEN  SHALL be the redirect base address (branch instruction PC).
REQ-016 redirect_imm  in  XLEN  SHALL be the signed redirect offset.

Function
REQ-017 The block SHALL own the PC register and an FSM with states IDLE, REQ, WAIT, HOLD, plus a 1-bit drop flag.
REQ-018 IDLE -> REQ unconditionally after one cycle; no outputs asserted in IDLE.
REQ-019 REQ: imem_req_valid=1, imem_req_addr=PC; imem_req_ready=1 -> WAIT; otherwise stay REQ.
REQ-020 WAIT: imem_rsp_valid=1 with drop=0 -> capture instr_data<=imem_rsp_data, instr_pc<=PC, PC<=PC+4, go HOLD.
REQ-021 HOLD: instr_valid=1; instr_ready=1 -> REQ; outputs SHALL stay stable while instr_ready=0.
REQ-022 At most one imem request SHALL be outstanding; minimum steady-state spacing is 3 cycles per instruction (REQ, WAIT, HOLD with ready=1, zero-latency imem).
REQ-023 PC increment and redirect target SHALL be computed modulo 2^XLEN; wrap from 2^XLEN-4 to 0 SHALL be silent; no alignment check.
REQ-024 Redirect target SHALL be redirect_base + redirect_imm; on redirect_valid=1 PC SHALL load the target at the next edge, overriding any PC+4 update in the same cycle.
REQ-025 Redirect in REQ without imem_req_ready: stay REQ; request withdrawn, re-presented next cycle with new address.
REQ-026 Redirect in REQ with imem_req_ready: go WAIT with drop=1.
REQ-027 Redirect in WAIT: drop=1; same-cycle imem_rsp_valid SHALL be discarded and FSM -> REQ.
REQ-028 WAIT with drop=1 and imem_rsp_valid=1: discard response, clear drop, -> REQ; PC unchanged.
REQ-029 Redirect in HOLD: -> REQ regardless of instr_ready; if instr_ready=1 that cycle the transfer counts as completed.
REQ-030 Redirect in IDLE: PC loads target; FSM -> REQ as normal.
REQ-031 imem_rsp_valid outside WAIT SHALL be ignored.

Reset
REQ-032 rst=1 at a rising edge SHALL set state=IDLE, PC=RESET_PC, drop=0, instr_data=0, instr_pc=0, regardless of state; rst has priority over redirect_valid.
REQ-033 While in IDLE after reset, imem_req_valid=0 and instr_valid=0; a response arriving after mid-WAIT reset SHALL be ignored (REQ-031).

Structure
REQ-034 State encoding (IDLE, REQ, WAIT, HOLD) and the increment constant 4 SHALL live in the shared cpu package.
REQ-035 One sub-module is natural: fetch_ctrl_fsm (next-state/output logic); PC register and adders stay in the top.

Verification
REQ-036 Reset, RESET_PC=0x100, imem ready=1 and rsp 1 cycle after accept, decode ready=1 -> instr_pc 0x100, 0x104, 0x108 on successive transfers, one per 3 cycles.
REQ-037 instr_ready held 0 for 5 cycles in HOLD -> instr_valid, instr_data, instr_pc stable for all 5; no new imem request issued.
REQ-038 Redirect base=0x200 imm=0xFFFFFFF0 in WAIT, rsp same cycle -> response dropped, next request addr 0x1F0.
REQ-039 Redirect in REQ with ready=1 -> next response discarded, following request addr = target; no instr_valid for the dropped word.
REQ-040 PC=0xFFFFFFFC fetched -> next request addr 0x00000000.
REQ-041 rst asserted in WAIT, then rsp_valid -> no instr_valid; first request after release at RESET_PC.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared fetch-unit types: FSM state encoding
// and the sequential PC increment.
package fetch_ctrl_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_HOLD = 2'd3
   } fetch_state_t;

   localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch bundle: imem request/response, decode
// handshake and redirect inputs.
interface fetch_ctrl_if #(
   parameter int XLEN = 32
);

   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_req_addr;
   logic            imem_rsp_valid;
   logic [31:0]     imem_rsp_data;
   logic            instr_valid;
   logic            instr_ready;
   logic [31:0]     instr_data;
   logic [XLEN-1:0] instr_pc;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_base;
   logic [XLEN-1:0] redirect_imm;

   modport master (
      output imem_req_valid,
      output imem_req_addr,
      input  imem_req_ready,
      input  imem_rsp_valid,
      input  imem_rsp_data,
      output instr_valid,
      output instr_data,
      output instr_pc,
      input  instr_ready,
      input  redirect_valid,
      input  redirect_base,
      input  redirect_imm
   );

   modport slave (
      input  imem_req_valid,
      input  imem_req_addr,
      output imem_req_ready,
      output imem_rsp_valid,
      output imem_rsp_data,
      input  instr_valid,
      input  instr_data,
      input  instr_pc,
      output instr_ready,
      output redirect_valid,
      output redirect_base,
      output redirect_imm
   );

endinterface

// File: rtl/fetch_ctrl_fsm.sv
// Fetch sequencing FSM: one outstanding imem
// request, drop tracking, registered strobes.
module fetch_ctrl_fsm
   import fetch_ctrl_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic req_ready,
   input  logic rsp_valid,
   input  logic instr_ready,
   input  logic redirect,
   output logic req_valid,
   output logic instr_valid,
   output logic capture
);

   fetch_state_t state;
   logic         drop;

   // A response is kept only if nothing made it stale.
   assign capture = (state == S_WAIT)
                  & rsp_valid
                  & ~drop
                  & ~redirect;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         drop        <= 1'b0;
         req_valid   <= 1'b0;
         instr_valid <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               state     <= S_REQ;
               req_valid <= 1'b1;
            end
            S_REQ: begin
               if (req_ready) begin
                  state     <= S_WAIT;
                  req_valid <= 1'b0;
                  drop      <= redirect;
               end
            end
            S_WAIT: begin
               if (rsp_valid) begin
                  drop <= 1'b0;
                  if (drop || redirect) begin
                     state     <= S_REQ;
                     req_valid <= 1'b1;
                  end else begin
                     state       <= S_HOLD;
                     instr_valid <= 1'b1;
                  end
               end else if (redirect) begin
                  drop <= 1'b1;
               end
            end
            S_HOLD: begin
               if (redirect || instr_ready) begin
                  state       <= S_REQ;
                  instr_valid <= 1'b0;
                  req_valid   <= 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: owns the PC and
// the instruction holding register toward decode.
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic         clk,
   input  logic         rst,
   fetch_ctrl_if.master bus
);

   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] target;
   logic [XLEN-1:0] pc_seq;
   logic [31:0]     data_q;
   logic [XLEN-1:0] ipc_q;
   logic            req_valid;
   logic            instr_valid;
   logic            capture;

   fetch_ctrl_fsm u_fsm (
      .clk         (clk),
      .rst         (rst),
      .req_ready   (bus.imem_req_ready),
      .rsp_valid   (bus.imem_rsp_valid),
      .instr_ready (bus.instr_ready),
      .redirect    (bus.redirect_valid),
      .req_valid   (req_valid),
      .instr_valid (instr_valid),
      .capture     (capture)
   );

   // Both adders wrap modulo 2^XLEN.
   assign target = bus.redirect_base
                 + bus.redirect_imm;
   assign pc_seq = pc + XLEN'(PC_INC);

   always_ff @(posedge clk) begin
      if (rst) begin
         pc     <= RESET_PC;
         data_q <= '0;
         ipc_q  <= '0;
      end else begin
         if (bus.redirect_valid) begin
            pc <= target;
         end else if (capture) begin
            pc <= pc_seq;
         end
         if (capture) begin
            data_q <= bus.imem_rsp_data;
            ipc_q  <= pc;
         end
      end
   end

   assign bus.imem_req_valid = req_valid;
   assign bus.imem_req_addr  = pc;
   assign bus.instr_valid    = instr_valid;
   assign bus.instr_data     = data_q;
   assign bus.instr_pc       = ipc_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl with a
// one-cycle-latency imem model.
module tb_fetch_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fetch_ctrl_if #(.XLEN(32)) bus ();

   fetch_ctrl #(
      .XLEN     (32),
      .RESET_PC (32'h100)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int n_acc  = 0;
   bit auto_rsp = 1'b1;

   logic [31:0] exp_pc_q[$];
   logic [31:0] exp_dat_q[$];
   int          xfer_cyc[$];

   function automatic logic [31:0] word_of(
      input logic [31:0] a);
      return a ^ 32'h5EED_0000;
   endfunction

   task automatic push_exp(input logic [31:0] a);
      exp_pc_q.push_back(a);
      exp_dat_q.push_back(word_of(a));
   endtask

   task automatic step();
      logic        acc;
      logic        xfer;
      logic [31:0] a;
      logic [31:0] ep;
      logic [31:0] ed;
      acc  = bus.imem_req_valid & bus.imem_req_ready;
      a    = bus.imem_req_addr;
      xfer = bus.instr_valid & bus.instr_ready;
      if (xfer === 1'b1) begin
         xfer_cyc.push_back(cyc);
         if (exp_pc_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_instr: pc=%h required none",
                     bus.instr_pc);
         end else begin
            ep = exp_pc_q.pop_front();
            ed = exp_dat_q.pop_front();
            checks++;
            if (bus.instr_pc !== ep) begin
               errors++;
               $display("FAIL instr_pc: got %h required %h",
                        bus.instr_pc, ep);
            end
            checks++;
            if (bus.instr_data !== ed) begin
               errors++;
               $display("FAIL instr_data: got %h required %h",
                        bus.instr_data, ed);
            end
         end
      end
      if (acc === 1'b1) n_acc++;
      @(posedge clk);
      #1;
      cyc++;
      bus.redirect_valid = 1'b0;
      bus.imem_rsp_valid = (acc === 1'b1) && auto_rsp;
      bus.imem_rsp_data  = (acc === 1'b1) ? word_of(a)
                                          : 32'hBAD0_BAD0;
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      bus.imem_req_ready = 1'b1;
      bus.instr_ready    = 1'b1;
      while (exp_pc_q.size() > 0 && n < 40) begin
         step();
         n++;
      end
      checks++;
      if (exp_pc_q.size() != 0) begin
         errors++;
         $display("FAIL %s_drain: pending=%0d required 0",
                  tag, exp_pc_q.size());
      end
      bus.imem_req_ready = 1'b0;
   endtask

   task automatic redirect(input logic [31:0] b,
                           input logic [31:0] i);
      bus.redirect_valid = 1'b1;
      bus.redirect_base  = b;
      bus.redirect_imm   = i;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      checks++;
      if (bus.imem_req_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_req_valid: got %b required 0",
                  bus.imem_req_valid);
      end
      checks++;
      if (bus.instr_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_instr_valid: got %b required 0",
                  bus.instr_valid);
      end
      checks++;
      if (bus.instr_pc !== 32'h0 ||
          bus.instr_data !== 32'h0) begin
         errors++;
         $display("FAIL rst_instr: pc=%h data=%h required 0",
                  bus.instr_pc, bus.instr_data);
      end
      rst = 1'b0;
      step();
      checks++;
      if (bus.imem_req_valid !== 1'b1 ||
          bus.imem_req_addr !== 32'h100) begin
         errors++;
         $display("FAIL first_req: v=%b addr=%h required 1/100",
                  bus.imem_req_valid, bus.imem_req_addr);
      end
   endtask

   task automatic test_sequential();
      xfer_cyc.delete();
      push_exp(32'h100);
      push_exp(32'h104);
      push_exp(32'h108);
      drain("seq");
      checks++;
      if (xfer_cyc.size() != 3) begin
         errors++;
         $display("FAIL seq_count: got %0d required 3",
                  xfer_cyc.size());
      end else begin
         checks++;
         if (xfer_cyc[1] - xfer_cyc[0] != 3 ||
             xfer_cyc[2] - xfer_cyc[1] != 3) begin
            errors++;
            $display("FAIL seq_spacing: got %0d,%0d required 3,3",
                     xfer_cyc[1] - xfer_cyc[0],
                     xfer_cyc[2] - xfer_cyc[1]);
         end
      end
   endtask

   task automatic test_hold_stall();
      int acc0;
      push_exp(32'h10C);
      bus.imem_req_ready = 1'b1;
      bus.instr_ready    = 1'b0;
      step();
      bus.imem_req_ready = 1'b0;
      step();
      acc0 = n_acc;
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (bus.instr_valid !== 1'b1 ||
             bus.imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_valid[%0d]: iv=%b rv=%b required 1/0",
                     k, bus.instr_valid, bus.imem_req_valid);
         end
         checks++;
         if (bus.instr_pc !== 32'h10C ||
             bus.instr_data !== word_of(32'h10C)) begin
            errors++;
            $display("FAIL hold_data[%0d]: pc=%h d=%h required 10c/%h",
                     k, bus.instr_pc, bus.instr_data,
                     word_of(32'h10C));
         end
         bus.imem_req_ready = 1'b1;
         step();
         bus.imem_req_ready = 1'b0;
      end
      checks++;
      if (n_acc != acc0) begin
         errors++;
         $display("FAIL hold_no_req: got %0d required %0d",
                  n_acc, acc0);
      end
      drain("hold");
   endtask

   task automatic test_redirect_wait();
      bus.imem_req_ready = 1'b1;
      bus.instr_ready    = 1'b1;
      step();
      bus.imem_req_ready = 1'b0;
      redirect(32'h200, 32'hFFFF_FFF0);
      step();
      checks++;
      if (bus.imem_req_valid !== 1'b1 ||
          bus.imem_req_addr !== 32'h1F0 ||
          bus.instr_valid !== 1'b0) begin
         errors++;
         $display("FAIL rdr_wait: rv=%b addr=%h iv=%b required 1/1f0/0",
                  bus.imem_req_valid, bus.imem_req_addr,
                  bus.instr_valid);
      end
      push_exp(32'h1F0);
      drain("rdr_wait");
   endtask

   task automatic test_redirect_req();
      int acc0;
      bus.imem_req_ready = 1'b1;
      redirect(32'h300, 32'h40);
      step();
      bus.imem_req_ready = 1'b0;
      step();
      checks++;
      if (bus.imem_req_valid !== 1'b1 ||
          bus.imem_req_addr !== 32'h340 ||
          bus.instr_valid !== 1'b0) begin
         errors++;
         $display("FAIL rdr_req: rv=%b addr=%h iv=%b required 1/340/0",
                  bus.imem_req_valid, bus.imem_req_addr,
                  bus.instr_valid);
      end
      push_exp(32'h340);
      drain("rdr_req");
      acc0 = n_acc;
      redirect(32'h400, 32'h8);
      step();
      checks++;
      if (bus.imem_req_valid !== 1'b1 ||
          bus.imem_req_addr !== 32'h408 ||
          n_acc != acc0) begin
         errors++;
         $display("FAIL rdr_stall: rv=%b addr=%h required 1/408",
                  bus.imem_req_valid, bus.imem_req_addr);
      end
      push_exp(32'h408);
      drain("rdr_stall");
   endtask

   task automatic test_redirect_hold();
      push_exp(32'h40C);
      bus.imem_req_ready = 1'b1;
      bus.instr_ready    = 1'b0;
      step();
      bus.imem_req_ready = 1'b0;
      step();
      checks++;
      if (bus.instr_valid !== 1'b1) begin
         errors++;
         $display("FAIL rdr_hold_iv: got %b required 1",
                  bus.instr_valid);
      end
      bus.instr_ready = 1'b1;
      redirect(32'h500, 32'h0);
      step();
      checks++;
      if (bus.imem_req_valid !== 1'b1 ||
          bus.imem_req_addr !== 32'h500 ||
          exp_pc_q.size() != 0) begin
         errors++;
         $display("FAIL rdr_hold: rv=%b addr=%h pend=%0d required 1/500/0",
                  bus.imem_req_valid, bus.imem_req_addr,
                  exp_pc_q.size());
      end
   endtask

   task automatic test_wrap();
      redirect(32'hFFFF_FFF0, 32'hC);
      step();
      checks++;
      if (bus.imem_req_addr !== 32'hFFFF_FFFC) begin
         errors++;
         $display("FAIL wrap_set: got %h required fffffffc",
                  bus.imem_req_addr);
      end
      push_exp(32'hFFFF_FFFC);
      drain("wrap");
      checks++;
      if (bus.imem_req_valid !== 1'b1 ||
          bus.imem_req_addr !== 32'h0) begin
         errors++;
         $display("FAIL wrap_next: rv=%b addr=%h required 1/0",
                  bus.imem_req_valid, bus.imem_req_addr);
      end
   endtask

   task automatic test_reset_wait();
      auto_rsp = 1'b0;
      bus.imem_req_ready = 1'b1;
      step();
      bus.imem_req_ready = 1'b0;
      rst = 1'b1;
      redirect(32'h800, 32'h0);
      step();
      rst = 1'b0;
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = 32'h1234_5678;
      checks++;
      if (bus.imem_req_valid !== 1'b0 ||
          bus.instr_valid !== 1'b0) begin
         errors++;
         $display("FAIL rstw_idle: rv=%b iv=%b required 0/0",
                  bus.imem_req_valid, bus.instr_valid);
      end
      step();
      checks++;
      if (bus.instr_valid !== 1'b0 ||
          bus.imem_req_valid !== 1'b1 ||
          bus.imem_req_addr !== 32'h100) begin
         errors++;
         $display("FAIL rstw_req: iv=%b rv=%b addr=%h required 0/1/100",
                  bus.instr_valid, bus.imem_req_valid,
                  bus.imem_req_addr);
      end
      step();
      checks++;
      if (bus.instr_valid !== 1'b0) begin
         errors++;
         $display("FAIL rstw_late: iv=%b required 0",
                  bus.instr_valid);
      end
      auto_rsp = 1'b1;
      checks++;
      if (exp_pc_q.size() != 0) begin
         errors++;
         $display("FAIL sb_empty: pending=%0d required 0",
                  exp_pc_q.size());
      end
   endtask

   initial begin
      bus.imem_req_ready = 1'b0;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = 32'h0;
      bus.instr_ready    = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_base  = 32'h0;
      bus.redirect_imm   = 32'h0;
      test_reset();
      test_sequential();
      test_hold_stall();
      test_redirect_wait();
      test_redirect_req();
      test_redirect_hold();
      test_wrap();
      test_reset_wait();
      $display("Result: errors=%0d of %0d checks",
               errors, checks);
      $finish;
   end

endmodule
